// File: rtl/step_decode_pkg.sv
// Shared stepper definitions: coil phase patterns and decoder FSM encoding,
// also used by the stepper driver side.
package step_decode_pkg;

    localparam logic [3:0] PAT_P0  = 4'b1001;
    localparam logic [3:0] PAT_P1  = 4'b1100;
    localparam logic [3:0] PAT_P2  = 4'b0110;
    localparam logic [3:0] PAT_P3  = 4'b0011;
    localparam logic [3:0] PAT_OFF = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] phase;
    } phase_info_t;

    // OFF is reported as not a legal phase; callers test for it separately.
    function automatic phase_info_t decode_phase(input logic [3:0] pat);
        phase_info_t r;
        r.legal = 1'b1;
        r.phase = 2'd0;
        case (pat)
            PAT_P0:  r.phase = 2'd0;
            PAT_P1:  r.phase = 2'd1;
            PAT_P2:  r.phase = 2'd2;
            PAT_P3:  r.phase = 2'd3;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/step_sync_filter.sv
// Two-flop synchronizer plus a persistence filter; emits each newly accepted
// coil pattern once, with a one-cycle strobe.
module step_sync_filter
    import step_decode_pkg::*;
#(
    parameter int FILT = 4
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [3:0] raw,
    output logic [3:0] pattern,
    output logic       strobe
);

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] cand;
    logic [3:0] run_len;
    logic [4:0] run_next;
    logic       stable;

    // run_next counts the current synchronized sample, so acceptance lands on
    // the FILT-th matching sample rather than one cycle later.
    always_comb begin
        run_next = (sync2 == cand) ? ({1'b0, run_len} + 5'd1) : 5'd1;
        stable   = (run_next >= 5'(FILT));
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1   <= PAT_OFF;
            sync2   <= PAT_OFF;
            cand    <= PAT_OFF;
            run_len <= 4'd0;
            pattern <= PAT_OFF;
            strobe  <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            cand    <= sync2;
            run_len <= stable ? 4'(FILT) : run_next[3:0];
            strobe  <= 1'b0;
            if (stable && (sync2 != pattern)) begin
                pattern <= sync2;
                strobe  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_decode.sv
// Stepper coil decoder: tracks phase sequence into a signed position,
// flags skipped steps or illegal drive patterns, and reports revolutions and stalls.
module step_decode
    import step_decode_pkg::*;
#(
    parameter int FILT          = 4,
    parameter int STEPS_PER_REV = 48,
    parameter int STALL_CYC     = 50000
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               STEP_A,
    input  logic               STEP_B,
    input  logic               STEP_AN,
    input  logic               STEP_BN,
    input  logic               CLR_ERR,
    output logic signed [15:0] POS,
    output logic               DIR,
    output logic               STEP_PULSE,
    output logic               REV_PULSE,
    output logic               ERR,
    output logic               STOPPED
);

    localparam int SW = $clog2(STALL_CYC + 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  phase;
    logic [1:0]  phase_next;
    logic [3:0]  pattern;
    logic        strobe;
    logic        fwd;
    logic        rev;
    phase_info_t info;
    logic [7:0]  rev_cnt;
    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] stall_next;

    step_sync_filter #(.FILT(FILT)) u_filter (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .raw     ({STEP_A, STEP_B, STEP_AN, STEP_BN}),
        .pattern (pattern),
        .strobe  (strobe)
    );

    // A clear coinciding with an illegal pattern wins; that pattern is then
    // ignored because the filter only strobes on a change.
    always_comb begin
        state_next = state;
        phase_next = phase;
        fwd        = 1'b0;
        rev        = 1'b0;
        info       = decode_phase(pattern);
        case (state)
            ST_IDLE: begin
                if (strobe) begin
                    if (info.legal) begin
                        state_next = ST_LOCKED;
                        phase_next = info.phase;
                    end else if (pattern != PAT_OFF) begin
                        state_next = CLR_ERR ? ST_IDLE : ST_FAULT;
                    end
                end
            end
            ST_LOCKED: begin
                if (strobe) begin
                    if (pattern == PAT_OFF) begin
                        state_next = ST_IDLE;
                    end else if (!info.legal) begin
                        state_next = CLR_ERR ? ST_IDLE : ST_FAULT;
                    end else if (info.phase == phase + 2'd1) begin
                        fwd        = 1'b1;
                        phase_next = info.phase;
                    end else if (info.phase == phase - 2'd1) begin
                        rev        = 1'b1;
                        phase_next = info.phase;
                    end else if (info.phase == phase + 2'd2) begin
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                if (CLR_ERR) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (fwd || rev) begin
            stall_next = '0;
        end else if (stall_cnt != SW'(STALL_CYC)) begin
            stall_next = stall_cnt + SW'(1);
        end else begin
            stall_next = stall_cnt;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= ST_IDLE;
            phase      <= 2'd0;
            POS        <= 16'sd0;
            DIR        <= 1'b0;
            STEP_PULSE <= 1'b0;
            REV_PULSE  <= 1'b0;
            ERR        <= 1'b0;
            STOPPED    <= 1'b0;
            rev_cnt    <= 8'd0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            STEP_PULSE <= fwd | rev;
            ERR        <= (state_next == ST_FAULT);
            stall_cnt  <= stall_next;
            STOPPED    <= (stall_next == SW'(STALL_CYC));
            REV_PULSE  <= 1'b0;
            if (fwd) begin
                POS <= POS + 16'sd1;
                DIR <= 1'b1;
                if (rev_cnt == 8'(STEPS_PER_REV - 1)) begin
                    rev_cnt   <= 8'd0;
                    REV_PULSE <= 1'b1;
                end else begin
                    rev_cnt <= rev_cnt + 8'd1;
                end
            end else if (rev) begin
                POS <= POS - 16'sd1;
                DIR <= 1'b0;
                if (rev_cnt == 8'd0) begin
                    rev_cnt   <= 8'(STEPS_PER_REV - 1);
                    REV_PULSE <= 1'b1;
                end else begin
                    rev_cnt <= rev_cnt - 8'd1;
                end
            end
        end
    end

endmodule
